// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data) arbiter in front of a
// single-port 32-bit memory. One access per SERVE cycle, fixed latency:
// request sampled in IDLE (cycle N), memory access in SERVE (N+1), registered
// ack in N+2. Ties are resolved round-robin; data wins the first tie after reset.
// Accesses that are misaligned, out of range, or data writes into the
// instruction region are rejected: they still take the SERVE cycle (with the
// write strobe suppressed) and return ack with err=1 and rdata=0.
//
// Ports:
//   clk, reset                       clock, async active-high reset
//   if_req/if_addr                   fetch request and byte address
//   if_ack/if_rdata/if_err           fetch completion, word, rejection flag
//   d_req/d_we/d_addr/d_wdata        data request, write enable, address, word
//   d_ack/d_rdata/d_err              data completion, word, rejection flag
//   mem_we/mem_addr/mem_wdata        memory controls (decoded from state)
//   mem_rdata                        combinational memory read data
module mem_arbiter #(
  parameter int IMEM_BYTES = 1024,
  parameter int MEM_BYTES  = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] IMEM_LIM = 32'(IMEM_BYTES);
  localparam logic [31:0] MEM_LIM  = 32'(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, SERVE_IF, SERVE_D} state_t;

  state_t      r_state, w_next;
  logic        r_last_if;   // 1 = fetch was granted last
  logic        r_we;
  logic        r_bad;       // latched access is rejected
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic w_if_v, w_d_v, w_grant_if, w_grant_d, w_if_bad, w_d_bad;

  // Request qualification and access checks, evaluated on the live inputs
  // so the verdict is latched together with the operands at grant time.
  always_comb begin
    // A port whose ack is still high is finishing its previous access.
    w_if_v     = if_req & ~if_ack;
    w_d_v      = d_req & ~d_ack;
    w_grant_d  = w_d_v & (~w_if_v | r_last_if);
    w_grant_if = w_if_v & ~w_grant_d;
    w_if_bad   = (if_addr[1:0] != 2'b00) | (if_addr >= IMEM_LIM);
    w_d_bad    = (d_addr[1:0] != 2'b00) | (d_addr >= MEM_LIM) |
                 (d_we & (d_addr < IMEM_LIM));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state and memory-side outputs, all decoded from state so reset
  // (which forces IDLE asynchronously) drops them within the same cycle.
  always_comb begin
    w_next    = r_state;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    case (r_state)
      IDLE: begin
        if (w_grant_d)       w_next = SERVE_D;
        else if (w_grant_if) w_next = SERVE_IF;
      end
      SERVE_IF: begin
        mem_addr = r_addr;
        w_next   = IDLE;
      end
      SERVE_D: begin
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        mem_we    = r_we & ~r_bad & ~reset;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_if <= 1'b1;
      r_we      <= 1'b0;
      r_bad     <= 1'b0;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      if_ack    <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= 32'h0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= 32'h0;
    end else begin
      if_ack <= 1'b0;
      if_err <= 1'b0;
      d_ack  <= 1'b0;
      d_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_addr    <= d_addr;
            r_we      <= d_we;
            r_wdata   <= d_wdata;
            r_bad     <= w_d_bad;
            r_last_if <= 1'b0;
          end else if (w_grant_if) begin
            r_addr    <= if_addr;
            r_we      <= 1'b0;
            r_wdata   <= 32'h0;
            r_bad     <= w_if_bad;
            r_last_if <= 1'b1;
          end
        end
        SERVE_IF: begin
          if_ack   <= 1'b1;
          if_err   <= r_bad;
          if_rdata <= r_bad ? 32'h0 : mem_rdata;
        end
        SERVE_D: begin
          d_ack <= 1'b1;
          d_err <= r_bad;
          // An accepted write leaves the previous read word in place.
          if (r_bad)      d_rdata <= 32'h0;
          else if (!r_we) d_rdata <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of directed transactions, randomized single
// transactions checked against a transaction-level reference model, and
// hand-written sequences for round-robin, protection and reset-during-write.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_ack, if_err, d_ack, d_err, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  mem_arbiter #(.IMEM_BYTES(1024), .MEM_BYTES(2048)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 2) ? 32'h1234ABCD : (32'hA5000000 | 32'(i));
  endfunction

  // Environment memory: combinational read, write on rising edge.
  logic [31:0] mem [0:511];
  logic        filled = 1'b0;
  always_comb mem_rdata = mem[mem_addr[10:2]];
  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
      filled <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr[10:2]] <= mem_wdata;
    end
  end

  // Reference model: memory image plus the last word each port returned.
  logic [31:0] ref_mem [0:511];
  logic [31:0] m_if_rd = 32'h0;
  logic [31:0] m_d_rd  = 32'h0;

  task automatic model(input bit is_d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] erd,
                       output bit eerr, output int ewe);
    ewe = 0;
    if (!is_d) begin
      eerr = (addr % 4 != 0) || (addr >= 1024);
      m_if_rd = eerr ? 32'h0 : ref_mem[addr >> 2];
      erd = m_if_rd;
    end else begin
      eerr = (addr % 4 != 0) || (addr >= 2048) || (we && addr < 1024);
      if (eerr) m_d_rd = 32'h0;
      else if (we) begin ref_mem[addr >> 2] = wdata; ewe = 1; end
      else m_d_rd = ref_mem[addr >> 2];
      erd = m_d_rd;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One transaction on one port; lat counts posedges from the sampling edge
  // until ack is seen (-1 on timeout).
  task automatic run(input bit is_d, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rd, output bit er,
                     output int lat, output int wes, output logic [31:0] we_addr,
                     output bit stray);
    repeat (2) @(negedge clk);
    if (is_d) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; end
    else begin if_req = 1; if_addr = addr; end
    lat = -1; wes = 0; stray = 0; we_addr = 0; rd = 0; er = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (mem_we) begin wes++; we_addr = mem_addr; end
      if (is_d ? if_ack : d_ack) stray = 1;
      if (is_d ? d_ack : if_ack) begin
        lat = n; rd = is_d ? d_rdata : if_rdata; er = is_d ? d_err : if_err;
        break;
      end else if (if_err || d_err) stray = 1;
    end
    if_req = 0; d_req = 0; d_we = 0;
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_rd;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_we;
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic [31:0] rd, erd, wa;
    bit er, eerr, stray, seen;
    int lat, wes, ewe;
    int ev_cyc[$];
    bit ev_d[$];

    for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
    tbl[0]  = '{0, 0, 32'h008, 32'h0,        1, 32'h1234ABCD, 0, 0};
    tbl[1]  = '{1, 1, 32'h400, 32'hDEADBEEF, 0, 32'h0,        0, 1};
    tbl[2]  = '{1, 0, 32'h400, 32'h0,        1, 32'hDEADBEEF, 0, 0};
    tbl[3]  = '{1, 1, 32'h010, 32'h11111111, 1, 32'h0,        1, 0};
    tbl[4]  = '{0, 0, 32'h006, 32'h0,        1, 32'h0,        1, 0};
    tbl[5]  = '{1, 0, 32'h800, 32'h0,        1, 32'h0,        1, 0};
    tbl[6]  = '{0, 0, 32'h3FC, 32'h0,        1, 32'hA50000FF, 0, 0};
    tbl[7]  = '{0, 0, 32'h400, 32'h0,        1, 32'h0,        1, 0};
    tbl[8]  = '{1, 0, 32'h7FC, 32'h0,        1, 32'hA50001FF, 0, 0};
    tbl[9]  = '{1, 1, 32'h7FC, 32'h000055AA, 1, 32'hA50001FF, 0, 1};
    tbl[10] = '{1, 0, 32'h7FC, 32'h0,        1, 32'h000055AA, 0, 0};
    tbl[11] = '{1, 0, 32'h402, 32'h0,        1, 32'h0,        1, 0};
    tbl[12] = '{1, 0, 32'h000, 32'h0,        1, 32'hA5000000, 0, 0};
    tbl[13] = '{1, 1, 32'h3FC, 32'h22222222, 1, 32'h0,        1, 0};

    reset = 1; if_req = 0; d_req = 0; d_we = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset acks/errs/we", {27'h0, if_ack, d_ack, if_err, d_err, mem_we}, 32'h0);
    chk("reset if_rdata", if_rdata, 32'h0);
    chk("reset d_rdata", d_rdata, 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    @(negedge clk); reset = 0;

    // Directed table
    foreach (tbl[i]) begin
      run(tbl[i].is_d, tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, er, lat, wes, wa, stray);
      model(tbl[i].is_d, tbl[i].we, tbl[i].addr, tbl[i].wdata, erd, eerr, ewe);
      chk($sformatf("tbl%0d latency", i), lat, 2);
      chk($sformatf("tbl%0d err", i), {31'h0, er}, {31'h0, tbl[i].exp_err});
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d mem_we cycles", i), wes, tbl[i].exp_we);
      if (tbl[i].exp_we != 0) chk($sformatf("tbl%0d mem_we addr", i), wa, tbl[i].addr);
      chk($sformatf("tbl%0d stray ack/err", i), {31'h0, stray}, 32'h0);
    end

    // Randomized single transactions vs. reference model
    for (int t = 0; t < 40; t++) begin
      bit is_d, we;
      logic [31:0] addr, wdata;
      int r;
      is_d = 1'($urandom % 2);
      we = is_d && ($urandom % 2 == 1);
      r = int'($urandom % 8);
      if (r < 5) addr = is_d ? ($urandom % 512) * 4 : ($urandom % 256) * 4;
      else if (r == 5) addr = 1024 + ($urandom % 256) * 4;
      else if (r == 6) addr = ($urandom % 2048) | 32'h1;
      else addr = 2048 + ($urandom % 64) * 4;
      wdata = $urandom;
      run(is_d, we, addr, wdata, rd, er, lat, wes, wa, stray);
      model(is_d, we, addr, wdata, erd, eerr, ewe);
      chk($sformatf("rnd%0d latency", t), lat, 2);
      chk($sformatf("rnd%0d err", t), {31'h0, er}, {31'h0, eerr});
      chk($sformatf("rnd%0d rdata", t), rd, erd);
      chk($sformatf("rnd%0d mem_we cycles", t), wes, ewe);
      chk($sformatf("rnd%0d stray", t), {31'h0, stray}, 32'h0);
    end

    // Round-robin with both ports held continuously after reset
    @(negedge clk); reset = 1;
    @(posedge clk);
    @(negedge clk); reset = 0;
    m_if_rd = 0; m_d_rd = 0;
    if_req = 1; if_addr = 32'h8; d_req = 1; d_we = 0; d_addr = 32'h0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (d_ack) begin
        ev_d.push_back(1); ev_cyc.push_back(n);
        chk("rr d_rdata", d_rdata, ref_mem[0]);
      end
      if (if_ack) begin
        ev_d.push_back(0); ev_cyc.push_back(n);
        chk("rr if_rdata", if_rdata, ref_mem[2]);
      end
    end
    if_req = 0; d_req = 0;
    chk("rr ack events", ev_cyc.size() >= 4 ? 32'd4 : ev_cyc.size(), 32'd4);
    for (int k = 0; k < 4 && k < ev_cyc.size(); k++) begin
      chk($sformatf("rr grant%0d is_data", k), {31'h0, ev_d[k]}, {31'h0, (k % 2 == 0)});
      chk($sformatf("rr grant%0d cycle", k), ev_cyc[k], 2 * (k + 1));
    end

    // Reset in the SERVE_D cycle of a write to 0x404
    repeat (2) @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 32'h404; d_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("rstw mem_we in serve", {31'h0, mem_we}, 32'h1);
    chk("rstw mem_addr in serve", mem_addr, 32'h404);
    #1 reset = 1;
    #1;
    chk("rstw mem_we dropped", {31'h0, mem_we}, 32'h0);
    chk("rstw mem_addr dropped", mem_addr, 32'h0);
    d_req = 0; d_we = 0;
    @(posedge clk); #1;
    chk("rstw outputs in reset", {27'h0, if_ack, d_ack, if_err, d_err, mem_we}, 32'h0);
    chk("rstw d_rdata in reset", d_rdata, 32'h0);
    @(negedge clk); reset = 0;
    m_if_rd = 0; m_d_rd = 0;
    seen = 0;
    repeat (4) begin @(posedge clk); #1; if (d_ack) seen = 1; end
    chk("rstw no late d_ack", {31'h0, seen}, 32'h0);
    chk("rstw word unchanged", mem[257], ref_mem[257]);
    run(1, 0, 32'h404, 32'h0, rd, er, lat, wes, wa, stray);
    model(1, 0, 32'h404, 32'h0, erd, eerr, ewe);
    chk("post-reset latency", lat, 2);
    chk("post-reset rdata", rd, erd);
    chk("post-reset err", {31'h0, er}, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
